// File: rtl/send_queue.sv
// Transmit FIFO feeding sendFrame: buffers host words and issues one start per framer ready episode.
// Optional occupancy output `level` is built when SEND_QUEUE_LEVEL_EN is defined.
module send_queue #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  push,
  input  logic [WIDTH-1:0]      push_data,
  output logic                  full,
  output logic                  empty,
  input  logic                  frame_ready_next,
  output logic                  start,
  output logic [WIDTH-1:0]      data
`ifdef SEND_QUEUE_LEVEL_EN
  ,
  output logic [DEPTH_LOG2:0]   level
`endif
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] PTR_ONE = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2:0] PTR_MSB = {1'b1, {DEPTH_LOG2{1'b0}}};

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_LOW = 2'd2
  } drainState_t;

  drainState_t stateReg, stateNext;

  logic [WIDTH-1:0]    mem [DEPTH];
  logic [DEPTH_LOG2:0] wrReg, rdReg;
  logic [DEPTH_LOG2:0] wrNext, rdNext;
  logic                pushOk, popOk;

  assign empty  = (wrReg == rdReg);
  assign full   = ((wrReg ^ rdReg) == PTR_MSB);
  assign pushOk = push && !full;
  assign popOk  = (stateReg == IDLE) && !empty && frame_ready_next;
  assign wrNext = pushOk ? wrReg + PTR_ONE : wrReg;
  assign rdNext = popOk  ? rdReg + PTR_ONE : rdReg;

  // WAIT_LOW holds off until ready drops so one ready level never admits two words.
  always_comb begin
    stateNext = stateReg;
    start     = 1'b0;
    case (stateReg)
      IDLE:     if (popOk) stateNext = ISSUE;
      ISSUE: begin
        start     = 1'b1;
        stateNext = WAIT_LOW;
      end
      WAIT_LOW: if (!frame_ready_next) stateNext = IDLE;
      default:  stateNext = IDLE;
    endcase
  end

  // Storage is not reset; only the pointers define which entries are valid.
  always_ff @(posedge clock) begin
    if (pushOk) mem[wrReg[DEPTH_LOG2-1:0]] <= push_data;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      stateReg <= IDLE;
      wrReg    <= '0;
      rdReg    <= '0;
      data     <= '0;
    end else begin
      stateReg <= stateNext;
      wrReg    <= wrNext;
      rdReg    <= rdNext;
      if (popOk) data <= mem[rdReg[DEPTH_LOG2-1:0]];
    end
  end

`ifdef SEND_QUEUE_LEVEL_EN
  logic [DEPTH_LOG2:0] levelReg;

  always_ff @(posedge clock) begin
    if (!reset_n) levelReg <= '0;
    else          levelReg <= wrNext - rdNext;
  end

  assign level = levelReg;
`endif

endmodule

// File: tb/tb_send_queue.sv
// Directed self-checking bench for send_queue; inputs driven and outputs sampled on the falling edge.
module tb_send_queue;

  localparam int WIDTH      = 8;
  localparam int DEPTH_LOG2 = 3;

  logic             clock;
  logic             reset_n;
  logic             push;
  logic [WIDTH-1:0] push_data;
  logic             full;
  logic             empty;
  logic             frame_ready_next;
  logic             start;
  logic [WIDTH-1:0] data;
`ifdef SEND_QUEUE_LEVEL_EN
  logic [DEPTH_LOG2:0] level;
`endif

  int nChecks = 0;
  int nPass   = 0;

  send_queue #(.WIDTH(WIDTH), .DEPTH_LOG2(DEPTH_LOG2)) dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .push             (push),
    .push_data        (push_data),
    .full             (full),
    .empty            (empty),
    .frame_ready_next (frame_ready_next),
    .start            (start),
    .data             (data)
`ifdef SEND_QUEUE_LEVEL_EN
    ,
    .level            (level)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic test_reset();
    reset_n = 1'b0; push = 1'b0; push_data = '0; frame_ready_next = 1'b1;
    @(negedge clock);
    reset_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      nChecks++;
      if (start !== 1'b0 || data !== 8'h00 || empty !== 1'b1 || full !== 1'b0)
        $display("FAIL reset_idle cyc=%0d got start=%b data=%h empty=%b full=%b want 0 00 1 0",
                 c, start, data, empty, full);
      else nPass++;
`ifdef SEND_QUEUE_LEVEL_EN
      nChecks++;
      if (level !== 4'd0) $display("FAIL reset_level got %0d want 0", level);
      else nPass++;
`endif
    end
    $display("reset: idle with ready high, no start");
  endtask

  task automatic test_single();
    frame_ready_next = 1'b1;
    push = 1'b1; push_data = 8'hA5;
    @(negedge clock);
    push = 1'b0;
    nChecks++;
    if (start !== 1'b0 || empty !== 1'b0)
      $display("FAIL single_latency1 got start=%b empty=%b want 0 0", start, empty);
    else nPass++;
    @(negedge clock);
    nChecks++;
    if (start !== 1'b1 || data !== 8'hA5 || empty !== 1'b1)
      $display("FAIL single_pulse got start=%b data=%h empty=%b want 1 a5 1", start, data, empty);
    else nPass++;
    for (int c = 0; c < 6; c++) begin
      @(negedge clock);
      nChecks++;
      if (start !== 1'b0 || data !== 8'hA5)
        $display("FAIL single_no_repeat cyc=%0d got start=%b data=%h want 0 a5", c, start, data);
      else nPass++;
    end
    frame_ready_next = 1'b0;
    @(negedge clock);
    $display("single: push a5 -> one start with data a5");
  endtask

  task automatic test_back_to_back();
    logic [WIDTH-1:0] expData [3] = '{8'h11, 8'h22, 8'h33};
    int               expCyc  [3] = '{2, 9, 17};
    logic [WIDTH-1:0] words   [3] = '{8'h11, 8'h22, 8'h33};
    int n = 0;
    for (int c = 0; c < 32; c++) begin
      @(negedge clock);
      if (start === 1'b1) begin
        nChecks++;
        if (n >= 3 || data !== expData[n] || c != expCyc[n])
          $display("FAIL b2b_pulse n=%0d got data=%h cyc=%0d want data=%h cyc=%0d",
                   n, data, c, (n < 3) ? expData[n] : 8'hxx, (n < 3) ? expCyc[n] : -1);
        else nPass++;
        n++;
      end
      frame_ready_next = (((c >> 2) & 1) == 0);
      push      = (c < 3);
      push_data = (c < 3) ? words[c] : 8'h00;
    end
    push = 1'b0; frame_ready_next = 1'b0;
    nChecks++;
    if (n != 3 || empty !== 1'b1) $display("FAIL b2b_count got %0d empty=%b want 3 1", n, empty);
    else nPass++;
    $display("back_to_back: 11 22 33 one per ready episode, pulses=%0d", n);
  endtask

  task automatic test_full_and_reject();
    int n = 0;
    frame_ready_next = 1'b0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clock);
      if (i > 0) begin
        nChecks++;
        if (full !== (i >= 8)) $display("FAIL full_flag after=%0d got %b want %b", i, full, (i >= 8));
        else nPass++;
      end
      push = 1'b1; push_data = i[WIDTH-1:0];
    end
    @(negedge clock);
    push = 1'b0;
    nChecks++;
    if (full !== 1'b1 || empty !== 1'b0) $display("FAIL full_after9 got full=%b empty=%b want 1 0", full, empty);
    else nPass++;
`ifdef SEND_QUEUE_LEVEL_EN
    nChecks++;
    if (level !== 4'd8) $display("FAIL full_level got %0d want 8", level);
    else nPass++;
`endif
    // Pop from IDLE while a push is offered to the still-full queue.
    frame_ready_next = 1'b1; push = 1'b1; push_data = 8'h5A;
    @(negedge clock);
    push = 1'b0; frame_ready_next = 1'b0;
    nChecks++;
    if (full !== 1'b0 || start !== 1'b1 || data !== 8'h00)
      $display("FAIL reject_pop got full=%b start=%b data=%h want 0 1 00", full, start, data);
    else nPass++;
`ifdef SEND_QUEUE_LEVEL_EN
    nChecks++;
    if (level !== 4'd7) $display("FAIL reject_level got %0d want 7", level);
    else nPass++;
`endif
    for (int c = 0; c < 30; c++) begin
      @(negedge clock);
      if (start === 1'b1) begin
        nChecks++;
        if (n >= 7 || data !== (n + 1))
          $display("FAIL drain_word n=%0d got %h want %h", n, data, n + 1);
        else nPass++;
        n++;
      end
      frame_ready_next = ((c % 3) == 0);
    end
    frame_ready_next = 1'b0;
    @(negedge clock);
    nChecks++;
    if (n != 7 || empty !== 1'b1) $display("FAIL drain_count got %0d empty=%b want 7 1", n, empty);
    else nPass++;
    $display("full: 9th push dropped, 5a rejected, drained %0d words", n);
  endtask

  task automatic test_reset_midflight();
    frame_ready_next = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push = 1'b1; push_data = 8'hC1 + i[WIDTH-1:0];
      @(negedge clock);
    end
    push = 1'b0; frame_ready_next = 1'b1;
    @(negedge clock);
    nChecks++;
    if (start !== 1'b1 || data !== 8'hC1) $display("FAIL mid_issue got start=%b data=%h want 1 c1", start, data);
    else nPass++;
    @(negedge clock);
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    nChecks++;
    if (start !== 1'b0 || data !== 8'h00 || empty !== 1'b1 || full !== 1'b0)
      $display("FAIL mid_reset got start=%b data=%h empty=%b full=%b want 0 00 1 0", start, data, empty, full);
    else nPass++;
`ifdef SEND_QUEUE_LEVEL_EN
    nChecks++;
    if (level !== 4'd0) $display("FAIL mid_reset_level got %0d want 0", level);
    else nPass++;
`endif
    for (int c = 0; c < 12; c++) begin
      frame_ready_next = ((c % 3) == 0);
      @(negedge clock);
      nChecks++;
      if (start !== 1'b0) $display("FAIL mid_no_start cyc=%0d got start=%b want 0", c, start);
      else nPass++;
    end
    frame_ready_next = 1'b0;
    $display("reset_midflight: queue discarded, no further starts");
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_full_and_reject();
    test_reset_midflight();
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
